serial_adder: RTL and testbench

Parametrised multi-cycle adder/subtractor built on the single-bit full-adder cell. It accepts two WIDTH-bit operands and a carry-in on a start strobe, then processes DIGIT bits per clock from LSB to MSB with a registered inter-digit carry. It returns a registered sum and carry-out with a one-cycle done pulse. It sits wherever area matters more than latency, for example in accumulators and address-step units.

---
 rtl/serial_adder.sv | 144 ++++++++++++++
 tb/tb_serial_adder.sv | 158 +++++++++++++++
 2 files changed

// File: rtl/serial_adder.sv
// Digit-serial adder/subtractor: DIGIT bits per clock, LSB first, registered carry between digits.
// Define SERIAL_ADDER_OVF_EN to build the two's-complement overflow flag; otherwise ovf is tied low.
module serial_adder #(
  parameter int WIDTH = 8,
  parameter int DIGIT = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             ci,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             co,
  output logic             ovf
);

  localparam int STEPS = WIDTH / DIGIT;
  localparam int CNT_W = (STEPS > 1) ? $clog2(STEPS) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(STEPS - 1);

  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d, res_q, res_d, sum_q, sum_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             carry_q, carry_d, co_q, co_d;
  logic [DIGIT:0]   dig;

  // Ripple of DIGIT full-adder cells; returns {carry out, digit sum}.
  function automatic logic [DIGIT:0] digit_add(input logic [DIGIT-1:0] x, input logic [DIGIT-1:0] y,
                                               input logic c);
    logic [DIGIT-1:0] s;
    logic             cr;
    cr = c;
    for (int i = 0; i < DIGIT; i++) begin
      s[i] = x[i] ^ y[i] ^ cr;
      cr   = (x[i] & y[i]) | (cr & (x[i] ^ y[i]));
    end
    return {cr, s};
  endfunction

  assign dig = digit_add(a_q[DIGIT-1:0], b_q[DIGIT-1:0], carry_q);

`ifdef SERIAL_ADDER_OVF_EN
  logic ovf_q, ovf_d, cmsb;

  // Carry into the top cell of the digit, i.e. into bit WIDTH-1 on the last step.
  function automatic logic msb_carry_in(input logic [DIGIT-1:0] x, input logic [DIGIT-1:0] y,
                                        input logic c);
    logic cr;
    cr = c;
    for (int i = 0; i < DIGIT - 1; i++) cr = (x[i] & y[i]) | (cr & (x[i] ^ y[i]));
    return cr;
  endfunction

  assign cmsb = msb_carry_in(a_q[DIGIT-1:0], b_q[DIGIT-1:0], carry_q);
`endif

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    res_d   = res_q;
    cnt_d   = cnt_q;
    carry_d = carry_q;
    sum_d   = sum_q;
    co_d    = co_q;
`ifdef SERIAL_ADDER_OVF_EN
    ovf_d   = ovf_q;
`endif
    case (state_q)
      // A start seen during DONE is taken at the edge that ends DONE, giving STEPS+1 spacing.
      IDLE, DONE: begin
        state_d = IDLE;
        if (start) begin
          a_d     = a;
          b_d     = b ^ {WIDTH{sub}};
          carry_d = ci;
          cnt_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        a_d     = WIDTH'({{DIGIT{1'b0}}, a_q} >> DIGIT);
        b_d     = WIDTH'({{DIGIT{1'b0}}, b_q} >> DIGIT);
        res_d   = WIDTH'({dig[DIGIT-1:0], res_q} >> DIGIT);
        carry_d = dig[DIGIT];
        cnt_d   = cnt_q + 1'b1;
        if (cnt_q == LAST) begin
          sum_d   = res_d;
          co_d    = dig[DIGIT];
`ifdef SERIAL_ADDER_OVF_EN
          ovf_d   = cmsb ^ dig[DIGIT];
`endif
          state_d = DONE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      carry_q <= 1'b0;
      sum_q   <= '0;
      co_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      carry_q <= carry_d;
      sum_q   <= sum_d;
      co_q    <= co_d;
    end
  end

  // Operand and shift registers carry no reset; they are always reloaded on accept.
  always_ff @(posedge clk) begin
    a_q   <= a_d;
    b_q   <= b_d;
    res_q <= res_d;
  end

`ifdef SERIAL_ADDER_OVF_EN
  always_ff @(posedge clk) begin
    if (rst) ovf_q <= 1'b0;
    else     ovf_q <= ovf_d;
  end
  assign ovf = ovf_q;
`else
  assign ovf = 1'b0;
`endif

  assign busy = (state_q == RUN);
  assign done = (state_q == DONE);
  assign sum  = sum_q;
  assign co   = co_q;

endmodule

// File: tb/tb_serial_adder.sv
// Directed bench for serial_adder: DIGIT = 1, 2 and 4 instances at WIDTH = 8.
module tb_serial_adder;

`ifdef SERIAL_ADDER_OVF_EN
  localparam bit OVF_ON = 1'b1;
`else
  localparam bit OVF_ON = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst, sub, ci;
  logic [7:0] a, b;
  logic [2:0] start_v, busy_v, done_v, co_v, ovf_v;
  logic [7:0] sum_v [3];
  int         sel;
  logic       busy_m, done_m, co_m, ovf_m;
  logic [7:0] sum_m;
  int         n_vec = 0;
  int         n_err = 0;

  always #5 clk = ~clk;

  serial_adder #(.WIDTH(8), .DIGIT(1)) dut1 (
    .clk(clk), .rst(rst), .start(start_v[0]), .sub(sub), .a(a), .b(b), .ci(ci),
    .busy(busy_v[0]), .done(done_v[0]), .sum(sum_v[0]), .co(co_v[0]), .ovf(ovf_v[0]));
  serial_adder #(.WIDTH(8), .DIGIT(2)) dut2 (
    .clk(clk), .rst(rst), .start(start_v[1]), .sub(sub), .a(a), .b(b), .ci(ci),
    .busy(busy_v[1]), .done(done_v[1]), .sum(sum_v[1]), .co(co_v[1]), .ovf(ovf_v[1]));
  serial_adder #(.WIDTH(8), .DIGIT(4)) dut4 (
    .clk(clk), .rst(rst), .start(start_v[2]), .sub(sub), .a(a), .b(b), .ci(ci),
    .busy(busy_v[2]), .done(done_v[2]), .sum(sum_v[2]), .co(co_v[2]), .ovf(ovf_v[2]));

  always_comb begin
    busy_m = busy_v[sel];
    done_m = done_v[sel];
    co_m   = co_v[sel];
    ovf_m  = ovf_v[sel];
    sum_m  = sum_v[sel];
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic do_op(input int s, input logic [7:0] av, input logic [7:0] bv, input logic civ,
                       input logic subv, input int steps, input logic [7:0] es, input logic eco,
                       input logic eovf, input string tag);
    int cyc, bcnt;
    @(posedge clk); #1;
    sel = s;
    start_v[s] = 1'b1;
    a = av; b = bv; ci = civ; sub = subv;
    @(posedge clk); #1;
    start_v = '0;
    a = ~av; b = ~bv; ci = ~civ; sub = ~subv;
    cyc = 0; bcnt = 0;
    while (!done_m && cyc < 40) begin
      bcnt += int'(busy_m);
      @(posedge clk); #1;
      cyc++;
    end
    check({tag, "_latency"}, cyc, steps);
    check({tag, "_busycyc"}, bcnt, steps);
    check({tag, "_sum"}, sum_m, es);
    check({tag, "_co"}, co_m, eco);
    check({tag, "_ovf"}, ovf_m, eovf & OVF_ON);
    check({tag, "_busy_at_done"}, busy_m, 0);
    @(posedge clk); #1;
    check({tag, "_done_pulse"}, done_m, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int  cyc;
    logic seen;
    rst = 1'b1; start_v = '0; a = '0; b = '0; ci = 1'b0; sub = 1'b0; sel = 0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    check("rst_busy", busy_m, 0);
    check("rst_done", done_m, 0);
    check("rst_sum", sum_m, 0);
    check("rst_co", co_m, 0);
    check("rst_ovf", ovf_m, 0);

    do_op(0, 8'h5A, 8'h3C, 1'b0, 1'b0, 8, 8'h96, 1'b0, 1'b1, "d1_5a_3c");
    do_op(0, 8'hFF, 8'h01, 1'b0, 1'b0, 8, 8'h00, 1'b1, 1'b0, "d1_ff_01");
    do_op(0, 8'h00, 8'h00, 1'b1, 1'b0, 8, 8'h01, 1'b0, 1'b0, "d1_cin");
    do_op(1, 8'h10, 8'h01, 1'b1, 1'b1, 4, 8'h0F, 1'b1, 1'b0, "d2_sub_10_01");
    do_op(1, 8'h01, 8'h02, 1'b1, 1'b1, 4, 8'hFF, 1'b0, 1'b0, "d2_sub_01_02");
    do_op(2, 8'h7F, 8'h01, 1'b0, 1'b0, 2, 8'h80, 1'b0, 1'b1, "d4_7f_01");
    do_op(2, 8'h80, 8'hFF, 1'b0, 1'b0, 2, 8'h7F, 1'b1, 1'b1, "d4_80_ff");
    repeat (3) @(posedge clk);
    #1 check("d4_hold_sum", sum_m, 8'h7F);

    // Start held high through RUN and DONE: first result uses the first operands,
    // the second start is taken at the edge that ends DONE.
    sel = 0;
    @(posedge clk); #1;
    start_v[0] = 1'b1; a = 8'h01; b = 8'h01; ci = 1'b0; sub = 1'b0;
    @(posedge clk); #1;
    a = 8'h40; b = 8'h40;
    cyc = 0;
    while (!done_m && cyc < 40) begin @(posedge clk); #1; cyc++; end
    check("hs_latency1", cyc, 8);
    check("hs_sum1", sum_m, 8'h02);
    @(posedge clk); #1;
    check("hs_accept2", busy_m, 1);
    check("hs_done_low", done_m, 0);
    start_v[0] = 1'b0;
    cyc = 1;
    while (!done_m && cyc < 40) begin @(posedge clk); #1; cyc++; end
    check("hs_spacing", cyc, 9);
    check("hs_sum2", sum_m, 8'h80);

    // Reset during RUN aborts the operation without a done pulse.
    do_op(0, 8'h5A, 8'h3C, 1'b0, 1'b0, 8, 8'h96, 1'b0, 1'b1, "rt_pre");
    @(posedge clk); #1;
    start_v[0] = 1'b1; a = 8'h11; b = 8'h22; ci = 1'b0; sub = 1'b0;
    @(posedge clk); #1;
    start_v[0] = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("rt_sum", sum_m, 0);
    check("rt_co", co_m, 0);
    check("rt_busy", busy_m, 0);
    check("rt_ovf", ovf_m, 0);
    seen = 1'b0;
    repeat (12) begin @(posedge clk); #1; if (done_m) seen = 1'b1; end
    check("rt_no_done", seen, 0);
    do_op(0, 8'h11, 8'h22, 1'b0, 1'b0, 8, 8'h33, 1'b0, 1'b0, "rt_post");

    // Reset and start on the same edge: reset wins, start dropped.
    @(posedge clk); #1;
    rst = 1'b1; start_v[0] = 1'b1; a = 8'h05; b = 8'h06;
    @(posedge clk); #1;
    rst = 1'b0; start_v[0] = 1'b0;
    check("rs_busy", busy_m, 0);
    check("rs_sum", sum_m, 0);
    seen = 1'b0;
    repeat (12) begin @(posedge clk); #1; if (done_m || busy_m) seen = 1'b1; end
    check("rs_dropped", seen, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
